// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
//   rs_state_t : sequencer FSM state encoding
//   max_int    : larger of two integers
//   width_of   : bits needed to count 0..n-1, never less than 1
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STAGGER = 2'd2,
    ST_DONE    = 2'd3
  } rs_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between a reset sequencer and its consumer.
//   sw_rst_req : synchronous software reset request (consumer -> sequencer)
//   rst_out    : per-channel active-high resets, bit 0 released first
//   ready      : all channels released, sequence complete
// modport master : the side issuing requests and observing resets
// modport slave  : the sequencer itself
interface reset_sequencer_if #(
  parameter int NUM_OUT = 4
);
  import reset_seq_pkg::*;

  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready;

  modport master (output sw_rst_req, input rst_out, input ready);
  modport slave  (input sw_rst_req, output rst_out, output ready);

endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Reset deassertion synchroniser: a chain of flops cleared asynchronously
// by rst and fed with constant 1, so sync_ok rises SYNC_STAGES edges after
// rst falls and drops immediately when rst asserts.
//   clk     : domain clock
//   rst     : asynchronous active-high raw reset
//   sync_ok : synchronised "reset released" indication
module reset_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: asynchronous assertion, synchronised deassertion, a
// minimum hold period, then staggered per-channel release of NUM_OUT resets.
// A software request re-runs hold/stagger without a power-on reset.
//   clk            : domain clock
//   rst            : asynchronous active-high raw reset
//   bus.sw_rst_req : synchronous software reset request
//   bus.rst_out    : per-channel active-high resets (registered)
//   bus.ready      : high once every channel is released (registered)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4,
  parameter int NUM_OUT     = 4
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   bus
);

  localparam int CNT_W = width_of(max_int(HOLD_CYCLES, STEP_CYCLES));
  localparam int IDX_W = width_of(NUM_OUT);
  localparam logic [NUM_OUT-1:0] CH0 = NUM_OUT'(1);

  generate
    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STEP_CYCLES < 1 || NUM_OUT < 1) begin : g_bad_params
      $error("reset_sequencer: illegal parameter set");
    end
  endgenerate

  rs_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_OUT-1:0] r_rst_out;
  logic               r_ready;

  rs_state_t          w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [NUM_OUT-1:0] w_rst_out_nxt;
  logic               w_ready_nxt;

  logic w_sync_ok;
  logic w_hold_end;
  logic w_step_end;
  logic w_last_ch;

  reset_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .sync_ok (w_sync_ok)
  );

  assign w_hold_end = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_step_end = (r_cnt == CNT_W'(STEP_CYCLES - 1));
  assign w_last_ch  = (r_idx == IDX_W'(NUM_OUT - 1));

  // State and output registers; rst forces the full-reset picture at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next-state logic. A software request outranks any release in progress.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ASSERT: begin
        if (w_sync_ok) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.sw_rst_req) w_state_nxt = ST_HOLD;
        else if (w_hold_end) w_state_nxt = (NUM_OUT == 1) ? ST_DONE : ST_STAGGER;
      end
      ST_STAGGER: begin
        if (bus.sw_rst_req) w_state_nxt = ST_HOLD;
        else if (w_step_end && w_last_ch) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.sw_rst_req) w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_ASSERT;
    endcase
  end

  // Next values of counter, index and the registered outputs.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_rst_out_nxt = r_rst_out;
    w_ready_nxt   = r_ready;
    if (r_state == ST_ASSERT) begin
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
    end else if (bus.sw_rst_req) begin
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_hold_end) begin
            w_rst_out_nxt = r_rst_out & ~CH0;
            w_idx_nxt     = IDX_W'(1);
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_STAGGER: begin
          if (w_step_end) begin
            w_rst_out_nxt = r_rst_out & ~(CH0 << r_idx);
            // Index parks on the last channel rather than wrapping.
            if (!w_last_ch) w_idx_nxt = r_idx + IDX_W'(1);
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          w_ready_nxt = 1'b1;
        end
        default: begin
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign bus.rst_out = r_rst_out;
  assign bus.ready   = r_ready;

endmodule
